// File: rtl/guess_entry_if.sv
// Keypad-to-controller bundle for guess_entry: the key strobe in, and the sent triple plus live entry view out.
// key_valid is a one-cycle strobe with no ready (every high cycle is one key); oNumRdy is a one-cycle valid pulse with no back-pressure, and oNum1..3 are stable while it is high.
interface guess_entry_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] oNum1;
    logic [3:0] oNum2;
    logic [3:0] oNum3;
    logic       oNumRdy;
    logic [1:0] entry_cnt;
    logic [3:0] entry_d1;
    logic [3:0] entry_d2;
    logic [3:0] entry_d3;
    logic       err;
    logic [7:0] sent_cnt;

    modport master (
        output key_code, key_valid,
        input  oNum1, oNum2, oNum3, oNumRdy,
        input  entry_cnt, entry_d1, entry_d2, entry_d3, err, sent_cnt
    );

    modport slave (
        input  key_code, key_valid,
        output oNum1, oNum2, oNum3, oNumRdy,
        output entry_cnt, entry_d1, entry_d2, entry_d3, err, sent_cnt
    );
endinterface

// File: rtl/guess_entry.sv
// Three-digit guess entry: buffers keypad digits with backspace/enter and sends the triple to the game controller.
// Every output is a register; the FSM state is visible on dbg_state (0 = EDIT, 1 = SEND).
module guess_entry #(
    parameter bit DISTINCT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    guess_entry_if.slave bus,
    output logic         dbg_state
);

    typedef enum logic {
        EDIT = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] KEY_BACK  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [3:0] num1_q, num1_d, num2_q, num2_d, num3_q, num3_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic [7:0] sent_q, sent_d;
    logic       dup;

    // Only filled slots take part, so a 0 into an empty buffer is not a repeat.
    assign dup = DISTINCT &&
                 (((cnt_q != 2'd0) && (d1_q == bus.key_code)) ||
                  ((cnt_q >= 2'd2) && (d2_q == bus.key_code)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EDIT;
            cnt_q   <= 2'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
            num1_q  <= 4'd0;
            num2_q  <= 4'd0;
            num3_q  <= 4'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            sent_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            num3_q  <= num3_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            sent_q  <= sent_d;
        end
    end

    // SEND always falls back to EDIT, and keys seen during SEND fall through untouched.
    always_comb begin
        state_d = EDIT;
        cnt_d   = cnt_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        num3_d  = num3_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        sent_d  = sent_q;
        if (state_q == EDIT && bus.key_valid) begin
            if (bus.key_code <= 4'd9) begin
                if (cnt_q == 2'd3 || dup) begin
                    err_d = 1'b1;
                end else begin
                    case (cnt_q)
                        2'd0:    d1_d = bus.key_code;
                        2'd1:    d2_d = bus.key_code;
                        default: d3_d = bus.key_code;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                end
            end else if (bus.key_code == KEY_BACK) begin
                if (cnt_q != 2'd0) begin
                    case (cnt_q)
                        2'd1:    d1_d = 4'd0;
                        2'd2:    d2_d = 4'd0;
                        default: d3_d = 4'd0;
                    endcase
                    cnt_d = cnt_q - 2'd1;
                end
            end else if (bus.key_code == KEY_ENTER) begin
                if (cnt_q == 2'd3) begin
                    num1_d  = d1_q;
                    num2_d  = d2_q;
                    num3_d  = d3_q;
                    rdy_d   = 1'b1;
                    d1_d    = 4'd0;
                    d2_d    = 4'd0;
                    d3_d    = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                    if (sent_q != 8'hFF) sent_d = sent_q + 8'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign bus.oNum1     = num1_q;
    assign bus.oNum2     = num2_q;
    assign bus.oNum3     = num3_q;
    assign bus.oNumRdy   = rdy_q;
    assign bus.entry_cnt = cnt_q;
    assign bus.entry_d1  = d1_q;
    assign bus.entry_d2  = d2_q;
    assign bus.entry_d3  = d3_q;
    assign bus.err       = err_q;
    assign bus.sent_cnt  = sent_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: one DISTINCT=1 instance for most scenarios, one DISTINCT=0 for repeated digits.
module tb_guess_entry;

    logic clk;
    logic reset;
    logic dbg1, dbg0;
    int   n_vec;
    int   n_bad;
    int   exp_sent;

    guess_entry_if if1 ();
    guess_entry_if if0 ();

    guess_entry #(.DISTINCT(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1), .dbg_state(dbg1));
    guess_entry #(.DISTINCT(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0), .dbg_state(dbg0));

    wire [36:0] all1 = {if1.oNum1, if1.oNum2, if1.oNum3, if1.oNumRdy, if1.entry_cnt,
                        if1.entry_d1, if1.entry_d2, if1.entry_d3, if1.err, if1.sent_cnt, dbg1};
    wire [36:0] all0 = {if0.oNum1, if0.oNum2, if0.oNum3, if0.oNumRdy, if0.entry_cnt,
                        if0.entry_d1, if0.entry_d2, if0.entry_d3, if0.err, if0.sent_cnt, dbg0};
    wire [13:0] view1 = {if1.entry_cnt, if1.entry_d1, if1.entry_d2, if1.entry_d3};
    wire [12:0] out1  = {if1.oNumRdy, if1.oNum1, if1.oNum2, if1.oNum3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the key is sampled at the next posedge and the task returns at the following negedge.
    task automatic press1(input logic [3:0] k);
        if1.key_code  = k;
        if1.key_valid = 1'b1;
        @(negedge clk);
        if1.key_valid = 1'b0;
    endtask

    task automatic press0(input logic [3:0] k);
        if0.key_code  = k;
        if0.key_valid = 1'b1;
        @(negedge clk);
        if0.key_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        if1.key_code = 4'd0; if1.key_valid = 1'b0;
        if0.key_code = 4'd0; if0.key_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (all1 !== 37'd0) begin n_bad++; $display("FAIL reset_dut1 got=%h exp=0", all1); end
        n_vec++;
        if (all0 !== 37'd0) begin n_bad++; $display("FAIL reset_dut0 got=%h exp=0", all0); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (all1 !== 37'd0) begin n_bad++; $display("FAIL reset_release got=%h exp=0", all1); end
    endtask

    task automatic test_basic;
        press1(4'd1);
        n_vec++;
        if (view1 !== {2'd1, 4'd1, 4'd0, 4'd0}) begin n_bad++; $display("FAIL basic_k1 got=%h exp=%h", view1, {2'd1, 4'd1, 4'd0, 4'd0}); end
        press1(4'd2);
        n_vec++;
        if (view1 !== {2'd2, 4'd1, 4'd2, 4'd0}) begin n_bad++; $display("FAIL basic_k2 got=%h exp=%h", view1, {2'd2, 4'd1, 4'd2, 4'd0}); end
        press1(4'd3);
        n_vec++;
        if (view1 !== {2'd3, 4'd1, 4'd2, 4'd3}) begin n_bad++; $display("FAIL basic_k3 got=%h exp=%h", view1, {2'd3, 4'd1, 4'd2, 4'd3}); end
        press1(4'hB);
        n_vec++;
        if (out1 !== {1'b1, 4'd1, 4'd2, 4'd3}) begin n_bad++; $display("FAIL basic_send got=%h exp=%h", out1, {1'b1, 4'd1, 4'd2, 4'd3}); end
        n_vec++;
        if ({view1, if1.sent_cnt, dbg1} !== {14'd0, 8'd1, 1'b1}) begin
            n_bad++; $display("FAIL basic_after got=%h exp=%h", {view1, if1.sent_cnt, dbg1}, {14'd0, 8'd1, 1'b1});
        end
        @(negedge clk);
        n_vec++;
        if ({out1, dbg1} !== {1'b0, 4'd1, 4'd2, 4'd3, 1'b0}) begin
            n_bad++; $display("FAIL basic_rdy_drop got=%h exp=%h", {out1, dbg1}, {1'b0, 4'd1, 4'd2, 4'd3, 1'b0});
        end
    endtask

    task automatic test_backspace;
        press1(4'd4);
        press1(4'd5);
        n_vec++;
        if (if1.entry_d2 !== 4'd5) begin n_bad++; $display("FAIL bs_d2_5 got=%0d exp=5", if1.entry_d2); end
        press1(4'hA);
        n_vec++;
        if (view1 !== {2'd1, 4'd4, 4'd0, 4'd0}) begin n_bad++; $display("FAIL bs_clear got=%h exp=%h", view1, {2'd1, 4'd4, 4'd0, 4'd0}); end
        press1(4'd6);
        n_vec++;
        if (if1.entry_d2 !== 4'd6) begin n_bad++; $display("FAIL bs_d2_6 got=%0d exp=6", if1.entry_d2); end
        press1(4'd7);
        press1(4'hB);
        n_vec++;
        if ({out1, if1.sent_cnt} !== {1'b1, 4'd4, 4'd6, 4'd7, 8'd2}) begin
            n_bad++; $display("FAIL bs_send got=%h exp=%h", {out1, if1.sent_cnt}, {1'b1, 4'd4, 4'd6, 4'd7, 8'd2});
        end
        @(negedge clk);
        press1(4'hA);
        n_vec++;
        if ({if1.err, view1} !== {1'b0, 14'd0}) begin n_bad++; $display("FAIL bs_empty got=%h exp=0", {if1.err, view1}); end
    endtask

    task automatic test_reject;
        press1(4'd2);
        press1(4'd2);
        n_vec++;
        if ({if1.err, if1.entry_cnt} !== {1'b1, 2'd1}) begin n_bad++; $display("FAIL rej_dup got=%b exp=101", {if1.err, if1.entry_cnt}); end
        @(negedge clk);
        n_vec++;
        if (if1.err !== 1'b0) begin n_bad++; $display("FAIL rej_err_single got=%b exp=0", if1.err); end
        press1(4'd3);
        press1(4'hB);
        n_vec++;
        if ({if1.err, if1.oNumRdy, if1.entry_cnt} !== {1'b1, 1'b0, 2'd2}) begin
            n_bad++; $display("FAIL rej_short_enter got=%b exp=1010", {if1.err, if1.oNumRdy, if1.entry_cnt});
        end
        press1(4'd4);
        press1(4'd5);
        n_vec++;
        if ({if1.err, view1} !== {1'b1, 2'd3, 4'd2, 4'd3, 4'd4}) begin
            n_bad++; $display("FAIL rej_full got=%h exp=%h", {if1.err, view1}, {1'b1, 2'd3, 4'd2, 4'd3, 4'd4});
        end
        press1(4'd5);
        n_vec++;
        if ({if1.err, view1} !== {1'b1, 2'd3, 4'd2, 4'd3, 4'd4}) begin
            n_bad++; $display("FAIL rej_back2back got=%h exp=%h", {if1.err, view1}, {1'b1, 2'd3, 4'd2, 4'd3, 4'd4});
        end
        press1(4'hB);
        n_vec++;
        if ({out1, if1.sent_cnt} !== {1'b1, 4'd2, 4'd3, 4'd4, 8'd3}) begin
            n_bad++; $display("FAIL rej_send got=%h exp=%h", {out1, if1.sent_cnt}, {1'b1, 4'd2, 4'd3, 4'd4, 8'd3});
        end
        @(negedge clk);
    endtask

    task automatic test_nondistinct;
        press0(4'd2);
        press0(4'd2);
        n_vec++;
        if ({if0.err, if0.entry_cnt} !== {1'b0, 2'd2}) begin n_bad++; $display("FAIL nd_dup got=%b exp=010", {if0.err, if0.entry_cnt}); end
        press0(4'd2);
        press0(4'hB);
        n_vec++;
        if ({if0.oNumRdy, if0.oNum1, if0.oNum2, if0.oNum3, if0.sent_cnt} !== {1'b1, 4'd2, 4'd2, 4'd2, 8'd1}) begin
            n_bad++; $display("FAIL nd_send got=%h exp=%h", {if0.oNumRdy, if0.oNum1, if0.oNum2, if0.oNum3, if0.sent_cnt},
                              {1'b1, 4'd2, 4'd2, 4'd2, 8'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_send_drop;
        press1(4'd1);
        press1(4'd2);
        press1(4'd3);
        press1(4'hB);
        press1(4'd9);
        n_vec++;
        if ({if1.oNumRdy, if1.err, view1, dbg1} !== {2'b00, 14'd0, 1'b0}) begin
            n_bad++; $display("FAIL drop_send_key got=%h exp=0", {if1.oNumRdy, if1.err, view1, dbg1});
        end
        press1(4'd9);
        n_vec++;
        if (view1 !== {2'd1, 4'd9, 4'd0, 4'd0}) begin n_bad++; $display("FAIL drop_next_key got=%h exp=%h", view1, {2'd1, 4'd9, 4'd0, 4'd0}); end
        press1(4'hA);
    endtask

    task automatic test_ignored;
        press1(4'd5);
        for (int k = 12; k < 16; k++) begin
            press1(4'(k));
            n_vec++;
            if ({if1.err, if1.oNumRdy, view1} !== {2'b00, 2'd1, 4'd5, 4'd0, 4'd0}) begin
                n_bad++; $display("FAIL ignored_%0h got=%h exp=%h", k, {if1.err, if1.oNumRdy, view1}, {2'b00, 2'd1, 4'd5, 4'd0, 4'd0});
            end
        end
        press1(4'hA);
    endtask

    task automatic test_async_reset;
        press1(4'd1);
        press1(4'd2);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (all1 !== 37'd0) begin n_bad++; $display("FAIL areset_mid got=%h exp=0", all1); end
        @(negedge clk);
        reset = 1'b1;
        press1(4'd1);
        press1(4'd2);
        press1(4'd3);
        press1(4'hB);
        #1 reset = 1'b0;
        #1;
        n_vec++;
        if (all1 !== 37'd0) begin n_bad++; $display("FAIL areset_send got=%h exp=0", all1); end
        n_vec++;
        if (all0 !== 37'd0) begin n_bad++; $display("FAIL areset_dut0 got=%h exp=0", all0); end
        @(negedge clk);
        reset = 1'b1;
        press1(4'd3);
        press1(4'd4);
        press1(4'd5);
        press1(4'hB);
        n_vec++;
        if ({out1, if1.sent_cnt} !== {1'b1, 4'd3, 4'd4, 4'd5, 8'd1}) begin
            n_bad++; $display("FAIL areset_fresh got=%h exp=%h", {out1, if1.sent_cnt}, {1'b1, 4'd3, 4'd4, 4'd5, 8'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        logic [3:0] a, b, c;
        exp_sent = 1;
        for (int i = 0; i < 260; i++) begin
            a = 4'(i % 10);
            b = 4'((i + 1) % 10);
            c = 4'((i + 2) % 10);
            press1(a);
            press1(b);
            press1(c);
            press1(4'hB);
            if (exp_sent < 255) exp_sent = exp_sent + 1;
            n_vec++;
            if ({out1, if1.sent_cnt} !== {1'b1, a, b, c, 8'(exp_sent)}) begin
                n_bad++; $display("FAIL sat_send_%0d got=%h exp=%h", i, {out1, if1.sent_cnt}, {1'b1, a, b, c, 8'(exp_sent)});
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({out1, if1.sent_cnt} !== {1'b0, 4'd9, 4'd0, 4'd1, 8'd255}) begin
            n_bad++; $display("FAIL sat_hold got=%h exp=%h", {out1, if1.sent_cnt}, {1'b0, 4'd9, 4'd0, 4'd1, 8'd255});
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_backspace();
        test_reject();
        test_nondistinct();
        test_send_drop();
        test_ignored();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/guess_entry.md
# guess_entry

Collects a three-digit guess from the keypad scanner's one-key-per-pulse stream and hands it to the game controller over the `iNum1/iNum2/iNum3/iNumRdy` interface. The first delivered triple becomes the game's answer, and every later triple is scored as a guess. The block supports backspace, enter, optional rejection of repeated digits, and a live entry view for the VGA text overlay. It sits between the keypad scanner and `control_game` in the top level.

## Interface
- `DISTINCT`, default 1: when 1, a digit already present in the entry buffer is rejected.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces every register to its reset value.
- `key_code` in 4: key value. 0x0–0x9 are digits, 0xA is backspace, 0xB is enter, 0xC–0xF are ignored.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`. Each high cycle counts as one key; debouncing is done upstream.
- `oNum1` out 4: first digit entered of the last sent triple. Drives `iNum1`.
- `oNum2` out 4: second digit of the last sent triple. Drives `iNum2`.
- `oNum3` out 4: third digit of the last sent triple. Drives `iNum3`.
- `oNumRdy` out 1: one-cycle pulse indicating `oNum1..3` carry a new triple. Drives `iNumRdy`.
- `entry_cnt` out 2: number of digits currently in the buffer, 0–3.
- `entry_d1` out 4: buffer slot 1. Unfilled slots read 0.
- `entry_d2` out 4: buffer slot 2. Unfilled slots read 0.
- `entry_d3` out 4: buffer slot 3. Unfilled slots read 0.
- `err` out 1: one-cycle pulse on any rejected key.
- `sent_cnt` out 8: number of triples sent since reset. Saturates at 255.

## Operation
- **States:**
  - EDIT: `entry_cnt` is 0–3.
  - SEND: lasts exactly one cycle.
- **Reset values:** all outputs 0, state EDIT.
- **Key handling in EDIT.** Only cycles with `key_valid`=1 are acted on.
  - **Digit with `entry_cnt`<3 that is accepted:** the digit is written to slot `entry_cnt`+1 and `entry_cnt` increments.
  - **Digit with `entry_cnt`<3, `DISTINCT`=1, and the digit equals a filled slot:** no buffer change; `err` pulses.
  - **Digit with `entry_cnt`=3:** no buffer change; `err` pulses.
  - **Backspace with `entry_cnt`>0:** the slot at `entry_cnt` is cleared to 0 and `entry_cnt` decrements.
  - **Backspace with `entry_cnt`=0:** ignored, with no `err`.
  - **Enter with `entry_cnt`=3:**
    - `oNum1..3` load `entry_d1..d3`.
    - `oNumRdy` is set.
    - The buffer clears and `entry_cnt` goes to 0.
    - `sent_cnt` increments, saturating at 255.
    - State goes to SEND.
  - **Enter with `entry_cnt`<3:** no change; `err` pulses.
  - **Codes 0xC–0xF:** ignored, with no `err`.
- **SEND:**
  - `oNumRdy` is high.
  - Any key this cycle is dropped silently, with no `err` and no buffer change.
  - Next state is EDIT.
- **Output hold:**
  - `oNum1..3` hold their value until the next enter; reset sets them to 0.
  - `oNumRdy` is never high for two consecutive cycles.
- **Duplicate check:** compares only against filled slots, so a 0 digit into an empty buffer is accepted.

## Timing
- All outputs are registered.
- A key sampled at edge t has its effect visible on `entry_*`, `err`, `sent_cnt` and `oNum*` after edge t.
- **Enter at edge t:**
  - `oNumRdy`=1 and `oNum1..3` are valid during cycle t+1.
  - `oNumRdy` returns to 0 after edge t+1.
  - A key at edge t+1 is dropped; keys are accepted again from edge t+2.
- `err` is high for exactly one cycle per rejected key. Back-to-back rejected keys give back-to-back `err` cycles.
- **Reset mid-entry or during SEND:** all state clears immediately, asynchronously, and any pending `oNumRdy` is lost. Reset release is synchronized externally.
- `oNum*` are stable whenever `oNumRdy`=1, meeting the controller's same-cycle capture.

## Test plan
- **Basic send.** Reset, then keys 1, 2, 3, enter.
  - `entry_cnt` steps 1→2→3.
  - `oNumRdy` pulses one cycle with `oNum1..3`=1,2,3.
  - `entry_cnt`=0 and `sent_cnt`=1.
- **Backspace.** Keys 4, 5, backspace, 6, 7, enter.
  - `entry_d2` goes 5→0→6.
  - Output is 4,6,7.
  - A backspace at `entry_cnt`=0 gives no `err`.
- **Rejections with `DISTINCT`=1.**
  - Keys 2, 2 → `err` pulses once and `entry_cnt`=1.
  - Enter with 2 digits → `err` pulses and there is no `oNumRdy`.
  - A 4th digit → `err` pulses and the slots are unchanged.
  - With `DISTINCT`=0, keys 2, 2, 2, enter → output 2,2,2.
- **SEND-cycle drop.** Enter, then key 9 on the next cycle.
  - 9 is dropped: `entry_cnt`=0, no `err`.
  - Key 9 one cycle later is accepted.
- **Async reset.** Assert `reset`=0 mid-entry and in the SEND cycle.
  - All outputs read 0 without waiting for a clock edge.
  - `oNumRdy` is cut short.
  - After release, a fresh 3-digit entry works.
- **Saturation and hold.** Send 256 triples.
  - `sent_cnt` stays 255.
  - `oNum*` hold the last triple between sends.
  - Keys 0xC–0xF never change state.
